// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with selectable first-word-fall-through mode,
// fill level, almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
//
// Ports:
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   i_flush           synchronous flush, overrides read and write
//   i_wr_en/i_wr_data write request and data
//   i_rd_en           read (pop) request
//   o_rd_data         read data (registered when Fwft=0, head word when Fwft=1)
//   o_rd_valid        Fwft=0: one-cycle pulse with new o_rd_data; Fwft=1: !o_empty
//   o_full/o_empty    occupancy at Depth / zero
//   o_almost_full     level >= AlmostFullThr
//   o_almost_empty    level <= AlmostEmptyThr
//   o_level           current occupancy, 0..Depth
//   o_overflow        sticky: write attempted while full
//   o_underflow       sticky: read attempted while empty
module sync_fifo #(
    parameter int Depth          = 4,
    parameter int Width          = 8,
    parameter bit Fwft           = 1'b0,
    parameter int AlmostFullThr  = 3,
    parameter int AlmostEmptyThr = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [Width-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [Width-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full,
    output logic                       o_almost_empty,
    output logic [$clog2(Depth):0]     o_level,
    output logic                       o_overflow,
    output logic                       o_underflow
);
    localparam int PW = $clog2(Depth);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(Depth);
    localparam logic [PW:0] LVL_AF   = (PW+1)'(AlmostFullThr);
    localparam logic [PW:0] LVL_AE   = (PW+1)'(AlmostEmptyThr);
    localparam logic [PW:0] ONE      = (PW+1)'(1);

    logic [Width-1:0] mem [Depth];
    logic [PW:0]      wr_ptr, rd_ptr, level;
    logic             wr_acc, rd_acc;

    // Flags are decoded from the registered level so they move with o_level.
    assign o_level        = level;
    assign o_full         = (level == LVL_FULL);
    assign o_empty        = (level == '0);
    assign o_almost_full  = (level >= LVL_AF);
    assign o_almost_empty = (level <= LVL_AE);

    // Acceptance looks only at start-of-cycle state, so a read never frees
    // room for a same-cycle write when full, and a write is never bypassed
    // to a same-cycle read when empty. Flush masks both.
    assign wr_acc = i_wr_en & ~o_full  & ~i_flush;
    assign rd_acc = i_rd_en & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
            if (i_wr_en && o_full)  o_overflow  <= 1'b1;
            if (i_rd_en && o_empty) o_underflow <= 1'b1;
        end
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[PW-1:0]] <= i_wr_data;
    end

    generate
        if (Fwft) begin : g_fwft
            assign o_rd_data  = mem[rd_ptr[PW-1:0]];
            assign o_rd_valid = ~o_empty;
        end else begin : g_reg
            logic [Width-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (i_flush) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr[PW-1:0]];
                end
            end

            assign o_rd_data  = rd_data_q;
            assign o_rd_valid = rd_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo. Two instances share the stimulus: u_reg
// (Fwft=0) feeds a scoreboard of expected read words checked by a monitor on
// every o_rd_valid pulse; u_fwft (Fwft=1) has its head word checked inline.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] r_data, f_data;
    logic       r_valid, r_full, r_empty, r_af, r_ae, r_ov, r_un;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [2:0] r_level, f_level;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo #(.Depth(4), .Width(8), .Fwft(1'b0), .AlmostFullThr(3), .AlmostEmptyThr(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(r_data), .o_rd_valid(r_valid), .o_full(r_full),
        .o_empty(r_empty), .o_almost_full(r_af), .o_almost_empty(r_ae), .o_level(r_level),
        .o_overflow(r_ov), .o_underflow(r_un));

    sync_fifo #(.Depth(4), .Width(8), .Fwft(1'b1), .AlmostFullThr(3), .AlmostEmptyThr(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(f_data), .o_rd_valid(f_valid), .o_full(f_full),
        .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae), .o_level(f_level),
        .o_overflow(f_ov), .o_underflow(f_un));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read-data pulse of the registered instance must match
    // the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && r_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h expected no read data at %0t", r_data, $time);
            end else begin
                chk("sb_rd_data", int'(r_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
        wr_en = wr; wr_data = d; rd_en = rd; flush = fl;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int lvl, input int full, input int empty,
                             input int af, input int ae, input int ov, input int un);
        chk({tag, "_level"}, int'(r_level), lvl);
        chk({tag, "_full"},  int'(r_full),  full);
        chk({tag, "_empty"}, int'(r_empty), empty);
        chk({tag, "_af"},    int'(r_af),    af);
        chk({tag, "_ae"},    int'(r_ae),    ae);
        chk({tag, "_ov"},    int'(r_ov),    ov);
        chk({tag, "_un"},    int'(r_un),    un);
        chk({tag, "_f_level"}, int'(f_level), lvl);
        chk({tag, "_f_valid"}, int'(f_valid), (empty == 0) ? 1 : 0);
    endtask

    logic [7:0] vec4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] wrap_rd [10] = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

    initial begin
        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_state("rst", 0, 0, 1, 0, 1, 0, 0);
        chk("rst_rd_valid", int'(r_valid), 0);
        chk("rst_rd_data", int'(r_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: fill and drain, registered read latency
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, vec4[i], 1'b0, 1'b0);
            chk_state("fill", i + 1, (i == 3) ? 1 : 0, 0, (i >= 2) ? 1 : 0, (i == 0) ? 1 : 0, 0, 0);
            chk("fill_f_head", int'(f_data), 32'h11);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vec4[i]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_rd_valid", int'(r_valid), 1);
            chk("drain_level", int'(r_level), 3 - i);
            if (i < 3) chk("drain_f_head", int'(f_data), int'(vec4[i + 1]));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_rd_valid", int'(r_valid), 0);
        chk("idle_rd_hold", int'(r_data), 32'h44);
        chk_state("drained", 0, 0, 1, 0, 1, 0, 0);

        // 3: full + rd + wr -> write rejected, overflow set
        for (int i = 0; i < 4; i++) cyc(1'b1, vec4[i], 1'b0, 1'b0);
        exp_q.push_back(8'h11);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("ovf_rd_data", int'(r_data), 32'h11);
        chk_state("ovf", 3, 0, 0, 1, 0, 1, 0);
        chk("ovf_f_ov", int'(f_ov), 1);
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(vec4[i]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_state("ovf_drained", 0, 0, 1, 0, 1, 1, 0);

        // 4: empty + rd + wr -> read rejected, underflow set
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        chk_state("unf", 1, 0, 0, 0, 1, 1, 1);
        chk("unf_rd_valid", int'(r_valid), 0);
        chk("unf_f_data", int'(f_data), 32'hA5);
        chk("unf_f_un", int'(f_un), 1);
        exp_q.push_back(8'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_level", int'(r_level), 0);

        // flush clears both sticky flags
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("flush1", 0, 0, 1, 0, 1, 0, 0);

        // 5: wrap with interleaved rd/wr at level 2
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(wrap_rd[i]);
            cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            chk("wrap_level", int'(r_level), 2);
            chk("wrap_f_head", int'(f_data), (i < 1) ? 32'h02 : (32'h10 + i - 1));
        end
        chk_state("wrap", 2, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(8'h18);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        exp_q.push_back(8'h19);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("wrap_end", 0, 0, 1, 0, 1, 0, 0);

        // 6: flush at level 3 with overflow, concurrent rd/wr ignored
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
        exp_q.push_back(8'hC1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("pre_flush", 3, 0, 0, 1, 0, 1, 0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        chk_state("flush2", 0, 0, 1, 0, 1, 0, 0);
        chk("flush2_rd_valid", int'(r_valid), 0);
        chk("flush2_rd_data", int'(r_data), 0);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_flush_f_head", int'(f_data), 32'h5A);
        exp_q.push_back(8'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_flush_level", int'(r_level), 0);

        // asynchronous reset mid-transfer drops buffered data at once
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 1, 0, 1, 0, 0);
        chk("async_rst_rd_data", int'(r_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        chk("sb_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
